// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end.
// Contents:
//   IQ_INSTR_W       default instruction width used by the issue queue
//   iq_state_t       issue-queue sequencer states
//   OP_* / field pos opcode and register-field constants used by the decoders
//   get_opcode/get_* field extraction helpers
package tomasulo_pkg;

   localparam int IQ_INSTR_W = 16;

   typedef enum logic [1:0] {
      IQ_IDLE = 2'd0,
      IQ_RUN  = 2'd1,
      IQ_DONE = 2'd2
   } iq_state_t;

   // Instruction layout: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 8;
   localparam int RS_LSB  = 4;
   localparam int RT_LSB  = 0;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;
   localparam logic [3:0] OP_LD  = 4'h4;
   localparam logic [3:0] OP_ST  = 4'h5;
   localparam logic [3:0] OP_NOP = 4'hF;

   function automatic logic [3:0] get_opcode(input logic [IQ_INSTR_W-1:0] instr);
      return instr[OPC_LSB +: 4];
   endfunction

   function automatic logic [3:0] get_rd(input logic [IQ_INSTR_W-1:0] instr);
      return instr[RD_LSB +: 4];
   endfunction

   function automatic logic [3:0] get_rs(input logic [IQ_INSTR_W-1:0] instr);
      return instr[RS_LSB +: 4];
   endfunction

   function automatic logic [3:0] get_rt(input logic [IQ_INSTR_W-1:0] instr);
      return instr[RT_LSB +: 4];
   endfunction

endpackage

// File: rtl/iq_fifo.sv
// Circular prefetch buffer holding {pc, instruction} entries.
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   push, wdata    append wdata at the tail (dropped when full unless popping)
//   pop            drop the head entry (ignored when empty)
//   clear          discard all entries; overrides push and pop
//   rdata          head entry (content undefined when empty)
//   full, empty    occupancy flags
//   count          occupancy, wide enough to hold FETCH_Q itself
module iq_fifo
   import tomasulo_pkg::*;
#(
   parameter int WIDTH   = IQ_INSTR_W,
   parameter int FETCH_Q = 4
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(FETCH_Q):0]   count
);

   localparam int PTR_W = $clog2(FETCH_Q);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FETCH_Q);

   logic [WIDTH-1:0] mem [FETCH_Q];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a push when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge Clock) begin
      if (!Reset && !clear && do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because FETCH_Q is a power of two.
   always_ff @(posedge Clock) begin
      if (Reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: loadable program store, fetch sequencer and a
// small prefetch buffer feeding reservation-station dispatch.
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   Run                     level enable; low while running pauses everything
//   LoadEn/LoadAddr/LoadData program store write (IDLE or DONE only)
//   ProgLen                 program length, captured when a run starts
//   Flush/FlushPc           redirect fetch to FlushPc, dropping prefetched work
//   disponivel              dispatch ready
//   enableOut               head instruction valid
//   instructionOut/pcOut    head instruction and its address (0 when empty)
//   done                    program fully issued
//
// state   | meaning
// IQ_IDLE | waiting for Run; program store writable
// IQ_RUN  | fetching into the buffer and issuing to dispatch
// IQ_DONE | every instruction issued; waits for Run low
module instr_issue_queue
   import tomasulo_pkg::*;
#(
   parameter int INSTR_W = IQ_INSTR_W,
   parameter int DEPTH   = 64,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int FETCH_Q = 4
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Run,
   input  logic               LoadEn,
   input  logic [ADDR_W-1:0]  LoadAddr,
   input  logic [INSTR_W-1:0] LoadData,
   input  logic [ADDR_W:0]    ProgLen,
   input  logic               Flush,
   input  logic [ADDR_W-1:0]  FlushPc,
   input  logic               disponivel,
   output logic               enableOut,
   output logic [INSTR_W-1:0] instructionOut,
   output logic [ADDR_W-1:0]  pcOut,
   output logic               done
);

   localparam int CNT_W  = $clog2(FETCH_Q) + 1;
   localparam int ENTRY_W = ADDR_W + INSTR_W;
   localparam logic [ADDR_W:0] PC_ONE = (ADDR_W+1)'(1);

   iq_state_t state;
   iq_state_t state_nxt;

   logic [INSTR_W-1:0] prog_mem [DEPTH];
   logic [ADDR_W:0]    fetch_pc;
   logic [ADDR_W:0]    len;

   logic               run_active;
   logic               start;
   logic               flush_take;
   logic               fetch_fire;
   logic               handshake;

   logic [ENTRY_W-1:0] fifo_wdata;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   assign run_active = (state == IQ_RUN) && Run;
   assign start      = (state == IQ_IDLE) && Run && (ProgLen != '0);
   assign flush_take = run_active && Flush;

   // The store read and the buffer write share one edge, so the read issued
   // this cycle is the only one ever in flight; a flush drops it by
   // suppressing the push.
   assign fetch_fire = run_active && (fetch_pc < len) && !fifo_full;
   assign fifo_wdata = {fetch_pc[ADDR_W-1:0], prog_mem[fetch_pc[ADDR_W-1:0]]};

   assign enableOut  = run_active && !fifo_empty;
   assign handshake  = enableOut && disponivel;
   assign done       = (state == IQ_DONE);

   assign pcOut          = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:INSTR_W];
   assign instructionOut = fifo_empty ? '0 : fifo_rdata[INSTR_W-1:0];

   always_ff @(posedge Clock) begin
      if (LoadEn && (state != IQ_RUN)) begin
         prog_mem[LoadAddr] <= LoadData;
      end
   end

   iq_fifo #(
      .WIDTH   (ENTRY_W),
      .FETCH_Q (FETCH_Q)
   ) u_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (fetch_fire && !flush_take),
      .pop   (handshake),
      .clear (flush_take),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IQ_IDLE: begin
            if (Run) state_nxt = (ProgLen != '0) ? IQ_RUN : IQ_DONE;
         end
         IQ_RUN: begin
            // >= so that a redirect past the end finishes once drained.
            if (run_active && !Flush && (fetch_pc >= len) && (fifo_count == '0))
               state_nxt = IQ_DONE;
         end
         IQ_DONE: begin
            if (!Run) state_nxt = IQ_IDLE;
         end
         default: state_nxt = IQ_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IQ_IDLE;
         fetch_pc <= '0;
         len      <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            fetch_pc <= '0;
            len      <= ProgLen;
         end else if (flush_take) begin
            fetch_pc <= {1'b0, FlushPc};
         end else if (fetch_fire) begin
            fetch_pc <= fetch_pc + PC_ONE;
         end
      end
   end

endmodule

// File: tb/tb_instr_issue_queue.sv
module tb_instr_issue_queue;

   logic        Clock;
   logic        Reset;
   logic        Run;
   logic        LoadEn;
   logic [5:0]  LoadAddr;
   logic [15:0] LoadData;
   logic [6:0]  ProgLen;
   logic        Flush;
   logic [5:0]  FlushPc;
   logic        disponivel;
   logic        enableOut;
   logic [15:0] instructionOut;
   logic [5:0]  pcOut;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] prog [7] = '{16'h0CA0, 16'h1B21, 16'h2C42, 16'h3D63,
                             16'h4E84, 16'h5FA5, 16'h6AC6};

   instr_issue_queue #(
      .INSTR_W (16),
      .DEPTH   (64),
      .FETCH_Q (4)
   ) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .Run            (Run),
      .LoadEn         (LoadEn),
      .LoadAddr       (LoadAddr),
      .LoadData       (LoadData),
      .ProgLen        (ProgLen),
      .Flush          (Flush),
      .FlushPc        (FlushPc),
      .disponivel     (disponivel),
      .enableOut      (enableOut),
      .instructionOut (instructionOut),
      .pcOut          (pcOut),
      .done           (done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expect consecutive handshakes for pcs first..last, one per cycle.
   task automatic drain(input string tag, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         chk({tag, "_en"}, 32'(enableOut), 32'd1);
         chk({tag, "_pc"}, 32'(pcOut), 32'(i));
         chk({tag, "_instr"}, 32'(instructionOut), 32'(prog[i]));
         tick();
      end
   endtask

   task automatic finish_run(input string tag);
      chk({tag, "_en_after"}, 32'(enableOut), 32'd0);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      tick();
      chk({tag, "_done"}, 32'(done), 32'd1);
      Run = 1'b0;
      tick();
      chk({tag, "_idle"}, 32'(done), 32'd0);
   endtask

   initial begin
      Reset = 1'b1; Run = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
      ProgLen = '0; Flush = 1'b0; FlushPc = '0; disponivel = 1'b0;
      tick();
      tick();
      chk("rst_en", 32'(enableOut), 32'd0);
      chk("rst_instr", 32'(instructionOut), 32'd0);
      chk("rst_pc", 32'(pcOut), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         LoadEn = 1'b1; LoadAddr = 6'(i); LoadData = prog[i];
         tick();
      end
      LoadEn = 1'b0;

      // Straight run: enableOut two edges after start, seven back-to-back issues.
      ProgLen = 7'd7; Run = 1'b1; disponivel = 1'b1;
      tick();
      chk("t1_en_start", 32'(enableOut), 32'd0);
      tick();
      drain("t1", 0, 6);
      finish_run("t1");

      // Dispatch stall: buffer fills, head holds, then resumes without gaps.
      Run = 1'b1;
      tick();
      tick();
      drain("t2a", 0, 0);
      chk("t2_pc1", 32'(pcOut), 32'd1);
      disponivel = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t2_hold_en", 32'(enableOut), 32'd1);
         chk("t2_hold_pc", 32'(pcOut), 32'd1);
         chk("t2_hold_instr", 32'(instructionOut), 32'(prog[1]));
      end
      disponivel = 1'b1;
      drain("t2b", 1, 6);
      finish_run("t2");

      // Flush to pc 2 on the handshake of pc 4.
      Run = 1'b1;
      tick();
      tick();
      drain("t3a", 0, 3);
      Flush = 1'b1; FlushPc = 6'd2;
      #1;
      chk("t3_flush_en", 32'(enableOut), 32'd1);
      chk("t3_flush_pc", 32'(pcOut), 32'd4);
      tick();
      Flush = 1'b0;
      chk("t3_gap_en", 32'(enableOut), 32'd0);
      tick();
      drain("t3b", 2, 6);
      finish_run("t3");

      // Pause after pc 3 issues; store write attempt while running.
      Run = 1'b1;
      tick();
      tick();
      drain("t4a", 0, 3);
      Run = 1'b0; LoadEn = 1'b1; LoadAddr = 6'd5; LoadData = 16'hFFFF;
      #1;
      chk("t4_pause_en0", 32'(enableOut), 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         LoadEn = 1'b0;
         chk("t4_pause_en", 32'(enableOut), 32'd0);
         chk("t4_pause_pc", 32'(pcOut), 32'd4);
         chk("t4_pause_done", 32'(done), 32'd0);
      end
      Run = 1'b1;
      #1;
      drain("t4b", 4, 6);
      finish_run("t4");

      // Empty program goes straight to DONE.
      ProgLen = 7'd0; Run = 1'b1;
      tick();
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_en", 32'(enableOut), 32'd0);
      tick();
      chk("t5_done2", 32'(done), 32'd1);
      chk("t5_en2", 32'(enableOut), 32'd0);
      Run = 1'b0;
      tick();
      chk("t5_idle", 32'(done), 32'd0);

      // Reset with three entries buffered, then restart and flush past the end.
      ProgLen = 7'd7; Run = 1'b1; disponivel = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("t6_pre_en", 32'(enableOut), 32'd1);
      chk("t6_pre_pc", 32'(pcOut), 32'd0);
      Reset = 1'b1;
      tick();
      chk("t6_rst_en", 32'(enableOut), 32'd0);
      chk("t6_rst_instr", 32'(instructionOut), 32'd0);
      chk("t6_rst_pc", 32'(pcOut), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      Reset = 1'b0; disponivel = 1'b1;
      tick();
      chk("t6_restart_en0", 32'(enableOut), 32'd0);
      tick();
      chk("t6_restart_en", 32'(enableOut), 32'd1);
      chk("t6_restart_pc", 32'(pcOut), 32'd0);
      chk("t6_restart_instr", 32'(instructionOut), 32'(prog[0]));
      Flush = 1'b1; FlushPc = 6'd7;
      tick();
      Flush = 1'b0;
      chk("t6_end_en", 32'(enableOut), 32'd0);
      chk("t6_end_done0", 32'(done), 32'd0);
      tick();
      chk("t6_end_done", 32'(done), 32'd1);
      Run = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
